// File: rtl/wav_dfi_lp_responder.sv
// PHY-side DFI low-power responder: one independent handshake engine each for
// the lp_ctrl and lp_data channels, with status, sticky errors and entry counts.

module wav_dfi_lp_responder_chan #(
  parameter int TLP_RESP   = 8,
  parameter int WAKE_SCALE = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             accept_en_i,
  input  logic [3:0]       ack_dly_i,
  input  logic             req_i,
  input  logic [5:0]       wakeup_i,
  input  logic             err_clr_i,
  output logic             ack_o,
  output logic             active_o,
  output logic [5:0]       wakeup_o,
  output logic             err_o,
  output logic [CNT_W-1:0] entry_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_REJECT,
    ST_ACK,
    ST_WAKE
  } state_e;

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       wakeup_q, wakeup_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] entry_q, entry_d;
  logic             ack_q;
  logic             active_q;

  logic [31:0]      lat_cycles;
  logic             lat_too_long;
  logic [63:0]      wake_prod;
  logic [CNT_W-1:0] wake_time;
  logic [CNT_W-1:0] entry_inc;

  // Acknowledge latency is cfg_ack_dly + 1; anything beyond tlp_resp is refused.
  assign lat_cycles   = 32'(ack_dly_i) + 32'd1;
  assign lat_too_long = lat_cycles > 32'(TLP_RESP);

  assign wake_prod = 64'(wakeup_q) * 64'(WAKE_SCALE);
  assign wake_time = (wake_prod > CNT_MAX) ? {CNT_W{1'b1}} : wake_prod[CNT_W-1:0];
  assign entry_inc = (entry_q == {CNT_W{1'b1}}) ? entry_q : entry_q + CNT_W'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    wakeup_d = wakeup_q;
    err_d    = err_q;
    entry_d  = entry_q;

    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          wakeup_d = wakeup_i;
          if (!accept_en_i || lat_too_long) begin
            state_d = ST_REJECT;
          end else if (ack_dly_i == 4'd0) begin
            state_d = ST_ACK;
            entry_d = entry_inc;
          end else begin
            state_d = ST_EVAL;
            cnt_d   = CNT_W'(ack_dly_i) - CNT_W'(1);
          end
        end
      end

      ST_EVAL: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
          entry_d = entry_inc;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_REJECT: begin
        if (!req_i) state_d = ST_IDLE;
      end

      ST_ACK: begin
        if (req_i) begin
          wakeup_d = wakeup_i;
        end else if (wake_time == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAKE;
          cnt_d   = wake_time - CNT_W'(1);
        end
      end

      ST_WAKE: begin
        // A request during wakeup is a protocol violation; the set wins over err_clr.
        if (req_i) err_d = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wakeup_q <= '0;
      err_q    <= 1'b0;
      entry_q  <= '0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wakeup_q <= wakeup_d;
      err_q    <= err_d;
      entry_q  <= entry_d;
      ack_q    <= (state_d == ST_ACK) || (state_d == ST_WAKE);
      active_q <= (state_d == ST_ACK);
    end
  end

  assign ack_o       = ack_q;
  assign active_o    = active_q;
  assign wakeup_o    = wakeup_q;
  assign err_o       = err_q;
  assign entry_cnt_o = entry_q;

endmodule

module wav_dfi_lp_responder #(
  parameter int TLP_RESP   = 8,
  parameter int WAKE_SCALE = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       cfg_accept_en,
  input  logic [3:0]       cfg_ack_dly,
  input  logic             lp_ctrl_req,
  input  logic [5:0]       lp_ctrl_wakeup,
  output logic             lp_ctrl_ack,
  input  logic             lp_data_req,
  input  logic [5:0]       lp_data_wakeup,
  output logic             lp_data_ack,
  output logic [1:0]       lp_active,
  output logic [11:0]      wakeup_q,
  output logic [1:0]       proto_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] entry_cnt_ctrl,
  output logic [CNT_W-1:0] entry_cnt_data
);

  wav_dfi_lp_responder_chan #(
    .TLP_RESP  (TLP_RESP),
    .WAKE_SCALE(WAKE_SCALE),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .accept_en_i(cfg_accept_en[0]),
    .ack_dly_i  (cfg_ack_dly),
    .req_i      (lp_ctrl_req),
    .wakeup_i   (lp_ctrl_wakeup),
    .err_clr_i  (err_clr),
    .ack_o      (lp_ctrl_ack),
    .active_o   (lp_active[0]),
    .wakeup_o   (wakeup_q[5:0]),
    .err_o      (proto_err[0]),
    .entry_cnt_o(entry_cnt_ctrl)
  );

  wav_dfi_lp_responder_chan #(
    .TLP_RESP  (TLP_RESP),
    .WAKE_SCALE(WAKE_SCALE),
    .CNT_W     (CNT_W)
  ) u_data (
    .clock      (clock),
    .reset      (reset),
    .accept_en_i(cfg_accept_en[1]),
    .ack_dly_i  (cfg_ack_dly),
    .req_i      (lp_data_req),
    .wakeup_i   (lp_data_wakeup),
    .err_clr_i  (err_clr),
    .ack_o      (lp_data_ack),
    .active_o   (lp_active[1]),
    .wakeup_o   (wakeup_q[11:6]),
    .err_o      (proto_err[1]),
    .entry_cnt_o(entry_cnt_data)
  );

endmodule

// File: tb/tb_wav_dfi_lp_responder.sv
// Scoreboard bench for wav_dfi_lp_responder: expectations are queued as stimulus
// is applied and retired against measured latencies, hold times and status.
`timescale 1ns/1ps

module tb_wav_dfi_lp_responder;

  localparam int TLP_RESP   = 8;
  localparam int WAKE_SCALE = 4;
  localparam int CNT_W      = 16;
  localparam int BOUND      = 100;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       cfg_accept_en;
  logic [3:0]       cfg_ack_dly;
  logic             lp_ctrl_req;
  logic [5:0]       lp_ctrl_wakeup;
  logic             lp_ctrl_ack;
  logic             lp_data_req;
  logic [5:0]       lp_data_wakeup;
  logic             lp_data_ack;
  logic [1:0]       lp_active;
  logic [11:0]      wakeup_q;
  logic [1:0]       proto_err;
  logic             err_clr;
  logic [CNT_W-1:0] entry_cnt_ctrl;
  logic [CNT_W-1:0] entry_cnt_data;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] obs;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt[2];

  wav_dfi_lp_responder #(
    .TLP_RESP  (TLP_RESP),
    .WAKE_SCALE(WAKE_SCALE),
    .CNT_W     (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_accept_en (cfg_accept_en),
    .cfg_ack_dly   (cfg_ack_dly),
    .lp_ctrl_req   (lp_ctrl_req),
    .lp_ctrl_wakeup(lp_ctrl_wakeup),
    .lp_ctrl_ack   (lp_ctrl_ack),
    .lp_data_req   (lp_data_req),
    .lp_data_wakeup(lp_data_wakeup),
    .lp_data_ack   (lp_data_ack),
    .lp_active     (lp_active),
    .wakeup_q      (wakeup_q),
    .proto_err     (proto_err),
    .err_clr       (err_clr),
    .entry_cnt_ctrl(entry_cnt_ctrl),
    .entry_cnt_data(entry_cnt_data)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int ch, input logic v);
    if (ch == 0) lp_ctrl_req = v;
    else         lp_data_req = v;
  endtask

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? lp_ctrl_ack : lp_data_ack;
  endfunction

  task automatic push(input string name, input int val);
    exp_t x;
    x.name = name;
    x.val  = val;
    sb_q.push_back(x);
  endtask

  // Steps until ack reaches lvl; returns the number of edges taken, or -1 on timeout.
  task automatic wait_ack(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack_of(ch) !== lvl && n < BOUND);
    if (ack_of(ch) !== lvl) n = -1;
  endtask

  task automatic wait_both(input logic lvl, output int r0, output int r1);
    r0 = -1;
    r1 = -1;
    for (int i = 1; i <= BOUND && (r0 < 0 || r1 < 0); i++) begin
      step();
      if (r0 < 0 && lp_ctrl_ack === lvl) r0 = i;
      if (r1 < 0 && lp_data_ack === lvl) r1 = i;
    end
  endtask

  task automatic count_ack(input int ch, input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ack_of(ch) !== 1'b0) highs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_accept_en = 2'b11; cfg_ack_dly = 4'd0; err_clr = 1'b0;
    lp_ctrl_req = 1'b0; lp_data_req = 1'b0; lp_ctrl_wakeup = '0; lp_data_wakeup = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    step();
    push("reset_ack", 0); push("reset_active", 0); push("reset_wakeup_q", 0);
    push("reset_proto_err", 0); push("reset_entry_cnt", 0);
    obs = {30'd0, lp_data_ack, lp_ctrl_ack}; e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(lp_active); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(wakeup_q); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(proto_err); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'({entry_cnt_data, entry_cnt_ctrl}); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_ctrl();
    int n;
    cfg_ack_dly = 4'd0; lp_ctrl_wakeup = 6'd0;
    set_req(0, 1'b1); push("basic_latency", 1);
    wait_ack(0, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("basic_active", 1);
    obs = 32'(lp_active[0]); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    repeat (4) step();
    set_req(0, 1'b0); push("basic_hold", 0); exp_cnt[0]++;
    wait_ack(0, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("basic_entry_ctrl", exp_cnt[0]);
    obs = 32'(entry_cnt_ctrl); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_data_wake();
    int n;
    cfg_ack_dly = 4'd3; lp_data_wakeup = 6'd5;
    set_req(1, 1'b1); push("wake_latency", 4);
    wait_ack(1, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    lp_data_wakeup = 6'd2; push("wake_track", 2);
    step();
    obs = 32'(wakeup_q[11:6]); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(1, 1'b0); push("wake_hold", 2 * WAKE_SCALE); exp_cnt[1]++;
    wait_ack(1, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("wake_entry_data", exp_cnt[1]);
    obs = 32'(entry_cnt_data); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_latency_max();
    int n;
    cfg_ack_dly = 4'd7; lp_ctrl_wakeup = 6'd0;
    set_req(0, 1'b1); push("max_latency", 8);
    step(); step();
    cfg_ack_dly = 4'd0; cfg_accept_en = 2'b10;
    wait_ack(0, 1'b1, n);
    obs = 32'((n < 0) ? -1 : n + 2); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    cfg_accept_en = 2'b11;
    set_req(0, 1'b0); push("max_hold", 0); exp_cnt[0]++;
    wait_ack(0, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("max_entry_ctrl", exp_cnt[0]);
    obs = 32'(entry_cnt_ctrl); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_reject_dly();
    int n, highs;
    cfg_ack_dly = 4'd8;
    set_req(0, 1'b1); push("reject_dly_acks", 0);
    count_ack(0, 12, highs);
    obs = 32'(highs); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(0, 1'b0);
    step();
    cfg_ack_dly = 4'd0;
    set_req(0, 1'b1); push("reject_dly_idle_latency", 1);
    wait_ack(0, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(0, 1'b0); push("reject_dly_hold", 0); exp_cnt[0]++;
    wait_ack(0, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reject_dly_entry_ctrl", exp_cnt[0]);
    obs = 32'(entry_cnt_ctrl); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_reject_en();
    int n, h1, h2;
    cfg_ack_dly = 4'd0; cfg_accept_en = 2'b10;
    set_req(0, 1'b1); push("reject_en_acks", 0);
    count_ack(0, 1, h1);
    cfg_accept_en = 2'b11;
    count_ack(0, 10, h2);
    obs = 32'(h1 + h2); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reject_en_entry_ctrl", exp_cnt[0]);
    obs = 32'(entry_cnt_ctrl); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(0, 1'b0);
    step();
    set_req(0, 1'b1); push("reject_en_idle_latency", 1);
    wait_ack(0, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(0, 1'b0); push("reject_en_hold", 0); exp_cnt[0]++;
    wait_ack(0, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_eval_withdraw();
    int n, highs;
    cfg_ack_dly = 4'd5; lp_data_wakeup = 6'd0;
    set_req(1, 1'b1);
    repeat (3) step();
    set_req(1, 1'b0); push("withdraw_acks", 0);
    count_ack(1, 10, highs);
    obs = 32'(highs); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("withdraw_entry_data", exp_cnt[1]);
    obs = 32'(entry_cnt_data); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    cfg_ack_dly = 4'd0;
    set_req(1, 1'b1); push("withdraw_idle_latency", 1);
    wait_ack(1, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(1, 1'b0); push("withdraw_hold", 0); exp_cnt[1]++;
    wait_ack(1, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_wake_reassert();
    int  n;
    bit  done;
    cfg_ack_dly = 4'd0; lp_ctrl_wakeup = 6'd3;
    set_req(0, 1'b1); push("reassert_latency", 1);
    wait_ack(0, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    exp_cnt[0]++;
    set_req(0, 1'b0); push("reassert_hold", 3 * WAKE_SCALE);
    n = 0; done = 1'b0;
    // Re-raise req two cycles into WAKE with err_clr held: the set must win.
    while (!done && n < BOUND) begin
      step();
      n++;
      if (lp_ctrl_ack === 1'b0) done = 1'b1;
      else if (n == 3) begin
        set_req(0, 1'b1); lp_ctrl_wakeup = 6'd0; err_clr = 1'b1;
      end
    end
    err_clr = 1'b0;
    obs = 32'(done ? n - 1 : -1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reassert_proto_err", 1);
    obs = 32'(proto_err); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reassert_new_ack", 1); exp_cnt[0]++;
    step();
    obs = 32'(lp_ctrl_ack); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reassert_new_wakeup", 0);
    obs = 32'(wakeup_q[5:0]); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    err_clr = 1'b1; push("reassert_err_clr", 0);
    step();
    err_clr = 1'b0;
    obs = 32'(proto_err); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(0, 1'b0); push("reassert_drop", 0);
    wait_ack(0, 1'b0, n);
    obs = 32'((n < 0) ? -1 : n - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("reassert_entry_ctrl", exp_cnt[0]);
    obs = 32'(entry_cnt_ctrl); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_concurrent();
    int r0, r1;
    cfg_ack_dly = 4'd2; lp_ctrl_wakeup = 6'd1; lp_data_wakeup = 6'd5;
    set_req(0, 1'b1); set_req(1, 1'b1);
    push("conc_latency_ctrl", 3); push("conc_latency_data", 3);
    wait_both(1'b1, r0, r1);
    obs = 32'(r0); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(r1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    exp_cnt[0]++; exp_cnt[1]++;
    set_req(0, 1'b0); set_req(1, 1'b0);
    push("conc_hold_ctrl", 1 * WAKE_SCALE); push("conc_hold_data", 5 * WAKE_SCALE);
    wait_both(1'b0, r0, r1);
    obs = 32'((r0 < 0) ? -1 : r0 - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'((r1 < 0) ? -1 : r1 - 1); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    push("conc_entry_both", (exp_cnt[1] << CNT_W) | exp_cnt[0]);
    obs = 32'({entry_cnt_data, entry_cnt_ctrl}); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  task automatic test_reset_in_wake();
    int n;
    cfg_ack_dly = 4'd0; lp_data_wakeup = 6'd10;
    set_req(1, 1'b1); push("rst_latency", 1);
    wait_ack(1, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(1, 1'b0);
    repeat (5) step();
    push("rst_pre_ack", 1); push("rst_pre_active", 0);
    obs = 32'(lp_data_ack); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(lp_active); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    reset = 1'b1; exp_cnt[0] = 0; exp_cnt[1] = 0;
    push("rst_ack", 0); push("rst_entry", 0); push("rst_wakeup_q", 0);
    step();
    obs = {30'd0, lp_data_ack, lp_ctrl_ack}; e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'({entry_cnt_data, entry_cnt_ctrl}); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    obs = 32'(wakeup_q); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    reset = 1'b0;
    step();
    lp_data_wakeup = 6'd0;
    set_req(1, 1'b1); push("rst_idle_latency", 1); exp_cnt[1]++;
    wait_ack(1, 1'b1, n);
    obs = 32'(n); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
    set_req(1, 1'b0);
    wait_ack(1, 1'b0, n);
    push("rst_entry_after", exp_cnt[1]);
    obs = 32'(entry_cnt_data); e = sb_q.pop_front(); n_checks++;
    if (obs !== 32'(e.val)) begin n_errors++; $display("FAIL %s: observed %0d, expected %0d", e.name, $signed(obs), e.val); end
  endtask

  initial begin
    test_reset();
    test_basic_ctrl();
    test_data_wake();
    test_latency_max();
    test_reject_dly();
    test_reject_en();
    test_eval_withdraw();
    test_wake_reassert();
    test_concurrent();
    test_reset_in_wake();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
